mac_dot_unit: RTL and testbench

Parametrised, pipelined signed dot-product engine, the successor to the single-lane `mac` cell. It multiplies LANES pairs of signed operands per beat, sums them, and accumulates across a packet of beats delimited by `in_last`. It returns one accumulated result per packet over a valid/ready handshake, with optional saturation and a sticky overflow flag. It is the compute core behind the AXI matrix accelerator's row×column datapath.

---
 rtl/mac_dot_unit.sv | 113 +++++++++++
 tb/tb_mac_dot_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_unit.sv
// Pipelined signed dot-product engine: LANES products per beat, accumulated per
// packet, one result per packet over valid/ready with optional saturation.
module mac_dot_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LANES  = 4,
  parameter bit          SAT    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  if (ACC_W < PROD_W + $clog2(LANES)) begin : g_acc_w_check
    $error("mac_dot_unit: ACC_W too narrow for DATA_W and LANES");
  end

  logic                     stall;
  logic                     s1_valid;
  logic                     s1_last;
  logic signed [PROD_W-1:0] s1_prod [LANES];

  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  base;
  logic signed [SUM_W-1:0]  nxt;
  logic [ACC_W-1:0]         res;
  logic [ACC_W-1:0]         acc;
  logic                     first;
  logic                     ovf_pkt;
  logic                     ovf;
  logic                     beat;

  // A held result blocks both pipeline stages and the input.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign beat     = !stall && s1_valid;

  // Stage 1: per-lane signed products.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
      end
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_prod[i] <= PROD_W'($signed(in_a[i*DATA_W +: DATA_W]))
                    * PROD_W'($signed(in_b[i*DATA_W +: DATA_W]));
      end
    end
  end

  // Stage 2 datapath: lane sum, accumulate one bit wide, then clamp or wrap.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(s1_prod[i]);
    end
    base = first ? '0 : SUM_W'($signed(acc));
    nxt  = base + sum;
    ovf  = nxt[SUM_W-1] != nxt[SUM_W-2];
    res  = nxt[ACC_W-1:0];
    if (SAT && ovf) begin
      res = nxt[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Stage 2 state: running accumulator, sticky overflow and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      first     <= 1'b1;
      ovf_pkt   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (beat) begin
        if (s1_last) begin
          acc     <= '0;
          first   <= 1'b1;
          ovf_pkt <= 1'b0;
          out_acc <= res;
          out_ovf <= ovf_pkt | ovf;
        end else begin
          acc     <= res;
          first   <= 1'b0;
          ovf_pkt <= ovf_pkt | ovf;
        end
      end
      if (beat && s1_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_unit.sv
// Scoreboard bench for mac_dot_unit: a default instance plus two 18-bit
// instances (saturating and wrapping) sharing the stimulus bus.
module tb_mac_dot_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 4;
  localparam int unsigned BW = DW * LN;

  typedef struct packed {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  localparam exp_t NONE = '{acc: 32'hdead_beef, ovf: 1'b1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic          sel = 1'b0;
  logic          rand_en = 1'b0;

  logic          v_main, v_sat;
  logic          rdy_m, rdy_s, rdy_w;
  logic          ov_m, ov_s, ov_w;
  logic          of_m, of_s, of_w;
  logic [31:0]   acc_m;
  logic [17:0]   acc_s, acc_w;

  int            checks = 0;
  int            errors = 0;
  exp_t          q_m[$];
  exp_t          q_s[$];
  exp_t          q_w[$];

  assign v_main = in_valid && !sel;
  assign v_sat  = in_valid && sel;

  always #5 clk = ~clk;

  mac_dot_unit #(.DATA_W(DW), .ACC_W(32), .LANES(LN), .SAT(1'b1)) u_main (
    .clk(clk), .rst(rst), .in_valid(v_main), .in_ready(rdy_m), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov_m), .out_ready(out_ready), .out_acc(acc_m), .out_ovf(of_m));

  mac_dot_unit #(.DATA_W(DW), .ACC_W(18), .LANES(LN), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(v_sat), .in_ready(rdy_s), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready), .out_acc(acc_s), .out_ovf(of_s));

  mac_dot_unit #(.DATA_W(DW), .ACC_W(18), .LANES(LN), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(v_sat), .in_ready(rdy_w), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov_w), .out_ready(out_ready), .out_acc(acc_w), .out_ovf(of_w));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic exp_t ex(input int a, input bit o);
    return '{acc: 32'(a), ovf: o};
  endfunction

  function automatic logic [BW-1:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [BW-1:0] spl(input int x);
    return pk(x, x, x, x);
  endfunction

  function automatic int rv();
    return int'($urandom_range(40, 0)) - 20;
  endfunction

  function automatic int dot(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int s = 0;
    for (int i = 0; i < int'(LN); i++) begin
      s += int'($signed(a[i*DW +: DW])) * int'($signed(b[i*DW +: DW]));
    end
    return s;
  endfunction

  // Drive one beat from posedge+1; acceptance decided by in_ready seen at negedge.
  task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic last);
    logic ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = sel ? rdy_s : rdy_m;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (q_m.size() + q_s.size() + q_w.size()) != 0; n++) idle();
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_en) out_ready = 1'($urandom_range(1, 0));
  end

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst && ov_m && out_ready) begin
      if (q_m.size() != 0) e = q_m.pop_front(); else e = NONE;
      chk("main_acc", acc_m, e.acc);
      chk("main_ovf", 32'(of_m), 32'(e.ovf));
    end
  end

  always @(negedge clk) begin : mon_sat
    exp_t e;
    if (!rst && ov_s && out_ready) begin
      if (q_s.size() != 0) e = q_s.pop_front(); else e = NONE;
      chk("sat_acc", 32'($signed(acc_s)), e.acc);
      chk("sat_ovf", 32'(of_s), 32'(e.ovf));
    end
  end

  always @(negedge clk) begin : mon_wrap
    exp_t e;
    if (!rst && ov_w && out_ready) begin
      if (q_w.size() != 0) e = q_w.pop_front(); else e = NONE;
      chk("wrap_acc", 32'($signed(acc_w)), e.acc);
      chk("wrap_ovf", 32'(of_w), 32'(e.ovf));
    end
  end

  initial begin
    int exp_sum;
    int nb;
    logic [BW-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(rdy_m), 32'd1);
    chk("rst_out_valid", 32'(ov_m), 32'd0);
    chk("rst_out_acc", acc_m, 32'd0);
    chk("rst_out_ovf", 32'(of_m), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat with latency check
    q_m.push_back(ex(20, 1'b0));
    send_beat(pk(1, 2, 3, 4), pk(4, 3, 2, 1), 1'b1);
    in_valid = 1'b0;
    chk("t1_lat_edge1", 32'(ov_m), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_lat_edge2", 32'(ov_m), 32'd1);
    idle();

    // Three signed beats, then a single beat proving the accumulator cleared
    q_m.push_back(ex(65544, 1'b0));
    send_beat(spl(3), spl(4), 1'b0);
    send_beat(spl(5), spl(-2), 1'b0);
    send_beat(spl(-128), spl(-128), 1'b1);
    q_m.push_back(ex(4, 1'b0));
    send_beat(spl(1), spl(1), 1'b1);
    drain();

    // Saturating and wrapping 18-bit instances
    sel = 1'b1;
    q_s.push_back(ex(131071, 1'b1));
    q_w.push_back(ex(-131072, 1'b1));
    send_beat(spl(-128), spl(-128), 1'b0);
    send_beat(spl(-128), spl(-128), 1'b1);
    drain();
    sel = 1'b0;

    // Backpressure: hold one result, a second beat in stage 1, a third waiting
    out_ready = 1'b0;
    q_m.push_back(ex(24, 1'b0));
    send_beat(spl(2), spl(3), 1'b1);
    q_m.push_back(ex(-28, 1'b0));
    send_beat(spl(-1), spl(7), 1'b1);
    q_m.push_back(ex(-4, 1'b0));
    in_a = spl(1); in_b = spl(-1); in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(rdy_m), 32'd0);
      chk("bp_out_acc", acc_m, 32'd24);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(spl(1), spl(-1), 1'b1);
    drain();

    // Four back-to-back random packets under random out_ready
    rand_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      nb = int'($urandom_range(4, 1));
      exp_sum = 0;
      for (int b = 0; b < nb; b++) begin
        ra = pk(rv(), rv(), rv(), rv());
        rb = pk(rv(), rv(), rv(), rv());
        exp_sum += dot(ra, rb);
        if (b == nb - 1) q_m.push_back(ex(exp_sum, 1'b0));
        send_beat(ra, rb, 1'(b == nb - 1));
      end
    end
    idle();
    rand_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset mid-packet discards the partial sum
    send_beat(spl(1), spl(1), 1'b0);
    send_beat(spl(1), spl(1), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 32'(rdy_m), 32'd1);
    chk("mid_rst_out_valid", 32'(ov_m), 32'd0);
    chk("mid_rst_out_acc", acc_m, 32'd0);
    chk("mid_rst_out_ovf", 32'(of_m), 32'd0);
    rst = 1'b0;
    q_m.push_back(ex(8, 1'b0));
    send_beat(spl(2), spl(1), 1'b1);
    drain();

    // Bubbles between beats of a four-beat packet
    q_m.push_back(ex(16, 1'b0));
    for (int i = 0; i < 4; i++) begin
      send_beat(spl(1), spl(1), 1'(i == 3));
      if (i < 3) idle();
    end
    in_valid = 1'b0;
    chk("bub_lat_edge1", 32'(ov_m), 32'd0);
    @(posedge clk);
    #1;
    chk("bub_lat_edge2", 32'(ov_m), 32'd1);
    drain();

    chk("q_main_empty", 32'(q_m.size()), 32'd0);
    chk("q_sat_empty", 32'(q_s.size()), 32'd0);
    chk("q_wrap_empty", 32'(q_w.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
